// File: rtl/conv_layer_sched.sv
// Layer scheduler in front of ConvCtrl: splits one layer descriptor into one
// instruction per 4-channel group and sequences reset/release/completion for each.
module conv_layer_sched #(
  parameter int MaxAddrWidth = 32,
  parameter int MaxPictWidth = 9,
  parameter int KernelSize   = 9,
  parameter int GrpWidth     = 8,
  parameter int RstCycles    = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    layer_valid_in,
  output logic                    layer_ready_out,
  input  logic [MaxAddrWidth-1:0] layer_wbase_in,
  input  logic [MaxAddrWidth-1:0] layer_dbase_in,
  input  logic [MaxPictWidth-1:0] layer_pict_in,
  input  logic [GrpWidth-1:0]     layer_groups_in,
  input  logic                    conv_done_in,
  output logic                    conv_rst_out,
  output logic [MaxAddrWidth-1:0] weight_addr0_out,
  output logic [MaxAddrWidth-1:0] weight_addr1_out,
  output logic [MaxAddrWidth-1:0] weight_addr2_out,
  output logic [MaxAddrWidth-1:0] weight_addr3_out,
  output logic [MaxAddrWidth-1:0] data_addr0_out,
  output logic [MaxAddrWidth-1:0] data_addr1_out,
  output logic [MaxAddrWidth-1:0] data_addr2_out,
  output logic [MaxAddrWidth-1:0] data_addr3_out,
  output logic [MaxPictWidth-1:0] pict_size_out,
  output logic                    conv_first_out,
  output logic                    conv_last_out,
  output logic                    inst_tag_out,
  output logic [GrpWidth-1:0]     group_idx_out,
  output logic                    busy_out,
  output logic                    layer_done_out
);
  localparam int AreaWidth = 2 * MaxPictWidth;
  localparam int CntWidth  = (RstCycles > 1) ? $clog2(RstCycles) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_RUN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [MaxAddrWidth-1:0] wcur_q, wcur_d, dcur_q, dcur_d;
  logic [MaxPictWidth-1:0] pict_q, pict_d;
  logic [GrpWidth-1:0]     groups_q, groups_d, g_q, g_d;
  logic [AreaWidth-1:0]    area_q, area_d;
  logic [CntWidth-1:0]     rcnt_q, rcnt_d;
  logic                    tag_q, tag_d;
  logic                    conv_rst_q, first_q, last_q, busy_q, done_q;
  logic [MaxAddrWidth-1:0] waddr_q [4];
  logic [MaxAddrWidth-1:0] daddr_q [4];

  assign layer_ready_out  = Rst && (state_q == S_IDLE);
  assign conv_rst_out     = conv_rst_q;
  assign weight_addr0_out = waddr_q[0];
  assign weight_addr1_out = waddr_q[1];
  assign weight_addr2_out = waddr_q[2];
  assign weight_addr3_out = waddr_q[3];
  assign data_addr0_out   = daddr_q[0];
  assign data_addr1_out   = daddr_q[1];
  assign data_addr2_out   = daddr_q[2];
  assign data_addr3_out   = daddr_q[3];
  assign pict_size_out    = pict_q;
  assign conv_first_out   = first_q;
  assign conv_last_out    = last_q;
  assign inst_tag_out     = tag_q;
  assign group_idx_out    = g_q;
  assign busy_out         = busy_q;
  assign layer_done_out   = done_q;

  // Next-state and operand bookkeeping for the layer sequencer.
  always_comb begin
    state_d  = state_q;
    wcur_d   = wcur_q;
    dcur_d   = dcur_q;
    pict_d   = pict_q;
    groups_d = groups_q;
    g_d      = g_q;
    area_d   = area_q;
    rcnt_d   = rcnt_q;
    tag_d    = tag_q;
    case (state_q)
      S_IDLE: begin
        if (layer_valid_in && layer_ready_out) begin
          wcur_d   = layer_wbase_in;
          dcur_d   = layer_dbase_in;
          pict_d   = layer_pict_in;
          groups_d = layer_groups_in;
          g_d      = {GrpWidth{1'b0}};
          state_d  = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        area_d = AreaWidth'(pict_q) * AreaWidth'(pict_q);
        rcnt_d = {CntWidth{1'b0}};
        if (groups_q == {GrpWidth{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rcnt_q == CntWidth'(RstCycles - 1)) begin
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + CntWidth'(1);
        end
      end
      S_RUN: begin
        if (conv_done_in) begin
          tag_d = ~tag_q;
          if (g_q == groups_q - GrpWidth'(1)) begin
            state_d = S_DONE;
          end else begin
            // Next group: four channels further on in both weight and data space.
            g_d     = g_q + GrpWidth'(1);
            wcur_d  = wcur_q + MaxAddrWidth'(4 * KernelSize);
            dcur_d  = dcur_q + (MaxAddrWidth'(area_q) << 2);
            rcnt_d  = {CntWidth{1'b0}};
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are derived from next-state values so
  // the operands are already valid in the first ISSUE cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      wcur_q     <= '0;
      dcur_q     <= '0;
      pict_q     <= '0;
      groups_q   <= '0;
      g_q        <= '0;
      area_q     <= '0;
      rcnt_q     <= '0;
      tag_q      <= 1'b0;
      conv_rst_q <= 1'b1;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        waddr_q[k] <= '0;
        daddr_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wcur_q     <= wcur_d;
      dcur_q     <= dcur_d;
      pict_q     <= pict_d;
      groups_q   <= groups_d;
      g_q        <= g_d;
      area_q     <= area_d;
      rcnt_q     <= rcnt_d;
      tag_q      <= tag_d;
      conv_rst_q <= (state_d != S_RUN);
      first_q    <= (g_d == {GrpWidth{1'b0}});
      last_q     <= (g_d == groups_d - GrpWidth'(1));
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      for (int k = 0; k < 4; k++) begin
        waddr_q[k] <= wcur_d + MaxAddrWidth'(k * KernelSize);
        daddr_q[k] <= dcur_d + MaxAddrWidth'(k) * MaxAddrWidth'(area_d);
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench for conv_layer_sched: two instances (RstCycles 2 and 1)
// driven through the same tasks, checked against a transaction-level model.
module tb_conv_layer_sched;
  localparam int AW = 32;
  localparam int PW = 9;
  localparam int GW = 8;
  localparam int KS = 9;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst, valid, done;
  logic [AW-1:0] wb_in, db_in;
  logic [PW-1:0] p_in;
  logic [GW-1:0] g_in;
  int            sel;
  logic          valid_s [2];
  logic          done_s  [2];

  logic          rdy_o [2], crst_o [2], first_o [2], last_o [2], tag_o [2];
  logic          busy_o [2], ldone_o [2];
  logic [AW-1:0] w_o [2][4];
  logic [AW-1:0] d_o [2][4];
  logic [PW-1:0] pict_o [2];
  logic [GW-1:0] gidx_o [2];

  logic          exp_tag [2];
  int            n_tests = 0;
  int            n_fail  = 0;

  assign valid_s[0] = valid && (sel == 0);
  assign valid_s[1] = valid && (sel == 1);
  assign done_s[0]  = done && (sel == 0);
  assign done_s[1]  = done && (sel == 1);

  conv_layer_sched #(.RstCycles(2)) u_dut_r2 (
    .Clk(Clk), .Rst(Rst), .layer_valid_in(valid_s[0]), .layer_ready_out(rdy_o[0]),
    .layer_wbase_in(wb_in), .layer_dbase_in(db_in), .layer_pict_in(p_in),
    .layer_groups_in(g_in), .conv_done_in(done_s[0]), .conv_rst_out(crst_o[0]),
    .weight_addr0_out(w_o[0][0]), .weight_addr1_out(w_o[0][1]),
    .weight_addr2_out(w_o[0][2]), .weight_addr3_out(w_o[0][3]),
    .data_addr0_out(d_o[0][0]), .data_addr1_out(d_o[0][1]),
    .data_addr2_out(d_o[0][2]), .data_addr3_out(d_o[0][3]),
    .pict_size_out(pict_o[0]), .conv_first_out(first_o[0]), .conv_last_out(last_o[0]),
    .inst_tag_out(tag_o[0]), .group_idx_out(gidx_o[0]), .busy_out(busy_o[0]),
    .layer_done_out(ldone_o[0])
  );

  conv_layer_sched #(.RstCycles(1)) u_dut_r1 (
    .Clk(Clk), .Rst(Rst), .layer_valid_in(valid_s[1]), .layer_ready_out(rdy_o[1]),
    .layer_wbase_in(wb_in), .layer_dbase_in(db_in), .layer_pict_in(p_in),
    .layer_groups_in(g_in), .conv_done_in(done_s[1]), .conv_rst_out(crst_o[1]),
    .weight_addr0_out(w_o[1][0]), .weight_addr1_out(w_o[1][1]),
    .weight_addr2_out(w_o[1][2]), .weight_addr3_out(w_o[1][3]),
    .data_addr0_out(d_o[1][0]), .data_addr1_out(d_o[1][1]),
    .data_addr2_out(d_o[1][2]), .data_addr3_out(d_o[1][3]),
    .pict_size_out(pict_o[1]), .conv_first_out(first_o[1]), .conv_last_out(last_o[1]),
    .inst_tag_out(tag_o[1]), .group_idx_out(gidx_o[1]), .busy_out(busy_o[1]),
    .layer_done_out(ldone_o[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d t=%0t): got %0h expected %0h", tag, sel, $time, obs, exp);
    end
  endtask

  // Operands of instruction i of a layer, from plain address arithmetic.
  task automatic check_ops(input logic [AW-1:0] wb, input logic [AW-1:0] db,
                           input int p, input int g, input int i);
    logic [AW-1:0] area, m, ew, ed;
    area = AW'(p * p);
    for (int k = 0; k < 4; k++) begin
      m  = AW'(4 * i + k);
      ew = wb + AW'((4 * i + k) * KS);
      ed = db + m * area;
      check_eq("weight_addr", w_o[sel][k], ew);
      check_eq("data_addr", d_o[sel][k], ed);
    end
    check_eq("pict_size", pict_o[sel], p);
    check_eq("conv_first", first_o[sel], (i == 0));
    check_eq("conv_last", last_o[sel], (i == g - 1));
    check_eq("group_idx", gidx_o[sel], i);
    check_eq("inst_tag", tag_o[sel], exp_tag[sel]);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, rdy_o[sel], 1);
    check_eq({tag, "_busy"}, busy_o[sel], 0);
    check_eq({tag, "_crst"}, crst_o[sel], 1);
    check_eq({tag, "_ldone"}, ldone_o[sel], 0);
    check_eq({tag, "_tag"}, tag_o[sel], exp_tag[sel]);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      check_idle("idle");
      done = 1'($urandom_range(1, 0));
    end
    @(negedge Clk);
    done = 1'b0;
    check_idle("idle_end");
  endtask

  // Enters and leaves at a negedge; the current negedge must be an IDLE cycle.
  task automatic run_layer(input logic [AW-1:0] wb, input logic [AW-1:0] db, input int p,
                           input int g, input int dmin, input int dmax, input bit hold,
                           input int abort_at);
    int r, dly;
    r = (sel == 0) ? 2 : 1;
    check_eq("ready_pre", rdy_o[sel], 1);
    valid = 1'b1; wb_in = wb; db_in = db; p_in = PW'(p); g_in = GW'(g);
    @(negedge Clk);
    if (hold) begin
      wb_in = $urandom; db_in = $urandom; p_in = PW'($urandom); g_in = GW'($urandom);
    end else begin
      valid = 1'b0;
    end
    check_eq("setup_ready", rdy_o[sel], 0);
    check_eq("setup_busy", busy_o[sel], 1);
    check_eq("setup_crst", crst_o[sel], 1);
    if (g == 0) begin
      @(negedge Clk);
      check_eq("g0_ldone", ldone_o[sel], 1);
      check_eq("g0_crst", crst_o[sel], 1);
      @(negedge Clk);
      valid = 1'b0;
      check_idle("g0_after");
      return;
    end
    for (int i = 0; i < g; i++) begin
      for (int c = 0; c < r; c++) begin
        @(negedge Clk);
        done = 1'($urandom_range(1, 0));
        check_eq("issue_crst", crst_o[sel], 1);
        check_eq("issue_busy", busy_o[sel], 1);
        check_eq("issue_ldone", ldone_o[sel], 0);
        check_ops(wb, db, p, g, i);
      end
      @(negedge Clk);
      done = 1'b0;
      check_eq("release_crst", crst_o[sel], 0);
      check_ops(wb, db, p, g, i);
      dly = $urandom_range(dmax, dmin);
      for (int j = 0; j < dly; j++) begin
        @(negedge Clk);
        check_eq("run_crst", crst_o[sel], 0);
        check_eq("run_ldone", ldone_o[sel], 0);
        check_eq("run_gidx", gidx_o[sel], i);
      end
      if (i == abort_at) begin
        Rst = 1'b0; valid = 1'b0;
        @(negedge Clk);
        check_eq("abort_busy", busy_o[sel], 0);
        check_eq("abort_crst", crst_o[sel], 1);
        check_eq("abort_tag", tag_o[sel], 0);
        check_eq("abort_ldone", ldone_o[sel], 0);
        check_eq("abort_ready", rdy_o[sel], 0);
        check_eq("abort_gidx", gidx_o[sel], 0);
        Rst = 1'b1;
        exp_tag[0] = 1'b0;
        exp_tag[1] = 1'b0;
        #1;
        check_eq("abort_ready_back", rdy_o[sel], 1);
        return;
      end
      done = 1'b1;
      exp_tag[sel] = ~exp_tag[sel];
    end
    @(negedge Clk);
    done = 1'b0;
    check_eq("done_pulse", ldone_o[sel], 1);
    check_eq("done_crst", crst_o[sel], 1);
    check_eq("done_ready", rdy_o[sel], 0);
    check_eq("done_tag", tag_o[sel], exp_tag[sel]);
    @(negedge Clk);
    valid = 1'b0;
    check_idle("after_layer");
  endtask

  initial begin
    Rst = 1'b0; valid = 1'b0; done = 1'b0; sel = 0;
    wb_in = '0; db_in = '0; p_in = '0; g_in = '0;
    exp_tag[0] = 1'b0;
    exp_tag[1] = 1'b0;
    repeat (3) @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      check_eq("rst_ready", rdy_o[s], 0);
      check_eq("rst_crst", crst_o[s], 1);
      check_eq("rst_busy", busy_o[s], 0);
      check_eq("rst_tag", tag_o[s], 0);
      check_eq("rst_ldone", ldone_o[s], 0);
      check_eq("rst_gidx", gidx_o[s], 0);
      check_eq("rst_waddr0", w_o[s][0], 0);
    end
    Rst = 1'b1;
    sel = 0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      run_layer(32'h0000_0000, 32'h0000_0080, 6, 3, 8, 8, 1'b0, -1);
      idle_cycles(3);
      run_layer(32'h0000_0064, 32'h0000_07D0, 5, 1, 0, 3, 1'b0, -1);
      run_layer(32'h0000_0007, 32'h0000_0009, 3, 0, 0, 0, 1'b0, -1);
      run_layer(32'hFFFF_FFF0, 32'hFFFF_FFF0, 4, 2, 1, 2, 1'b0, -1);
      check_eq("wrap_tag_idle", tag_o[sel], exp_tag[sel]);
      run_layer(32'h0000_1000, 32'h0000_2000, 7, 3, 2, 4, 1'b1, -1);
      run_layer(32'h0000_0000, 32'h0000_0080, 6, 3, 2, 2, 1'b0, 1);
      run_layer(32'h0000_0000, 32'h0000_0080, 6, 2, 1, 3, 1'b0, -1);
      idle_cycles(2);
      for (int n = 0; n < 8; n++) begin
        run_layer($urandom, $urandom, $urandom_range(511, 1), $urandom_range(5, 0),
                  0, $urandom_range(5, 0), 1'($urandom_range(1, 0)), -1);
      end
      idle_cycles(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
